// File: rtl/onboard_sweep_pkg.sv
// onboard_sweep_pkg: shared state encoding, pattern modes and pattern function for onboard_sweep_gen
package onboard_sweep_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RST_PULSE, S_DWELL, S_DONE} state_t;
  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam int PAT_W = 32;
  // Switch pattern for a sweep index; callers truncate to their switch width
  function automatic logic [PAT_W-1:0] f(input logic [1:0] mode, input logic [PAT_W-1:0] idx);
    return mode == MODE_GRAY ? idx ^ (idx >> 1) : mode == MODE_WALK ? PAT_W'(1) << idx : idx;
  endfunction
endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: shared reset-pulse / dwell counter with hold and a terminal-cycle pulse
module sweep_dwell_timer #(
  parameter int DWELL = 100,
  parameter int RST_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  input  logic dwell_i,
  input  logic hold_i,
  output logic term_o
);
  localparam int MAX = DWELL > RST_CYC ? DWELL : RST_CYC;
  localparam int CW = $clog2(MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic adv;
  // Hold only freezes the dwell phase; the reset pulse always runs to length
  always_comb begin
    lim = dwell_i ? CW'(DWELL - 1) : CW'(RST_CYC - 1);
    adv = run_i & ~(dwell_i & hold_i);
    term_o = adv & (cnt_q == lim);
    cnt_d = clr_i | term_o ? '0 : adv ? cnt_q + 1'b1 : cnt_q;
  end
  // Counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/onboard_sweep_gen.sv
// onboard_sweep_gen: reset-pulse then switch/key sweep sequencer; ONBOARD_SWEEP_SIG_EN adds a response signature
module onboard_sweep_gen import onboard_sweep_pkg::*; #(
  parameter int SW_W = 10,
  parameter int KEY_W = 3,
  parameter int DWELL = 100,
  parameter int RST_CYC = 10,
  parameter int RSP_W = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             hold_i,
  input  logic [1:0]       mode_i,
  input  logic [RSP_W-1:0] rsp_i,
  output logic [SW_W-1:0]  sw_o,
  output logic [KEY_W:0]   key_n_o,
  output logic             step_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [RSP_W-1:0] sig_o
);
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [SW_W-1:0] idx_q, idx_d, last_idx;
  logic [KEY_W-1:0] key_q, key_d;
  logic step_q, step_d, term, busy, clr_all, wrap, fin, adv;
  sweep_dwell_timer #(.DWELL(DWELL), .RST_CYC(RST_CYC)) u_timer (
    .clk(clk), .rst(rst), .clr_i(start_i | abort_i | ~busy), .run_i(busy),
    .dwell_i(state_q == S_DWELL), .hold_i(hold_i), .term_o(term)
  );
  // Sweep bookkeeping: pass wrap, final pattern of the last pass, and pattern advance
  always_comb begin
    busy = state_q == S_RST_PULSE || state_q == S_DWELL;
    clr_all = start_i | abort_i | (state_q == S_IDLE);
    last_idx = mode_q == MODE_WALK ? SW_W'(SW_W - 1) : '1;
    wrap = state_q == S_DWELL && term && idx_q == last_idx;
    fin = wrap && key_q == '0;
    adv = state_q == S_DWELL && term && !fin;
  end
  // State register
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // Next state: abort beats start, start restarts from any state
  always_comb state_d = abort_i ? S_IDLE : start_i ? S_RST_PULSE :
                        state_q == S_RST_PULSE && term ? S_DWELL : fin ? S_DONE : state_q;
  // Datapath next values; key field counts down once per completed pass
  always_comb begin
    mode_d = start_i ? (mode_i == 2'd3 ? MODE_BIN : mode_i) : mode_q;
    idx_d = clr_all ? '0 : adv ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    key_d = clr_all ? '1 : adv && wrap ? key_q - 1'b1 : key_q;
    step_d = !clr_all && adv;
  end
  // Datapath registers
  always_ff @(posedge clk) begin
    mode_q <= rst ? MODE_BIN : mode_d;
    idx_q <= rst ? '0 : idx_d;
    key_q <= rst ? '1 : key_d;
    step_q <= rst ? 1'b0 : step_d;
  end
  // Outputs decoded from state and registered sweep position
  always_comb begin
    sw_o = state_q == S_IDLE ? '0 : SW_W'(f(mode_q, PAT_W'(idx_q)));
    key_n_o = {state_q != S_RST_PULSE, key_q};
    step_o = step_q;
    busy_o = busy;
    done_o = state_q == S_DONE;
  end
`ifdef ONBOARD_SWEEP_SIG_EN
  logic [RSP_W-1:0] sig_q, sig_d;
  // Rotate-xor fold of the response, sampled on each terminal dwell cycle
  always_comb sig_d = clr_all ? '0 : state_q == S_DWELL && term ? {sig_q[RSP_W-2:0], sig_q[RSP_W-1]} ^ rsp_i : sig_q;
  // Signature register
  always_ff @(posedge clk) sig_q <= rst ? '0 : sig_d;
  assign sig_o = sig_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^rsp_i;
  assign sig_o = '0;
`endif
endmodule
